// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: datapath widths, integer-degree arctangent table
// and FSM encoding, used by both the rotation and vectoring paths.
package cordic_pkg;

  localparam int ITER = 7;
  localparam int IW   = 10;
  localparam int AW   = 9;
  localparam int CW   = 3;

  localparam logic [CW-1:0]        LAST_STEP = CW'(ITER - 1);
  localparam logic signed [AW-1:0] QUARTER   = AW'(90);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  function automatic logic signed [AW-1:0] atan_deg(input logic [CW-1:0] i);
    case (i)
      3'd0:    return AW'(45);
      3'd1:    return AW'(27);
      3'd2:    return AW'(14);
      3'd3:    return AW'(7);
      3'd4:    return AW'(4);
      3'd5:    return AW'(2);
      3'd6:    return AW'(1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One combinational vectoring iteration: drives y toward zero and accumulates
// the rotated angle in z.
module cordic_vec_step
  import cordic_pkg::*;
(
  input  logic signed [IW-1:0] x,
  input  logic signed [IW-1:0] y,
  input  logic signed [AW-1:0] z,
  input  logic        [CW-1:0] shift,
  input  logic signed [AW-1:0] atan_val,
  output logic signed [IW-1:0] x_next,
  output logic signed [IW-1:0] y_next,
  output logic signed [AW-1:0] z_next
);

  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;
  logic                 y_neg;

  assign x_sh  = x >>> shift;
  assign y_sh  = y >>> shift;
  assign y_neg = y[IW-1];

  // Rotate clockwise while y is positive, counter-clockwise while negative.
  assign x_next = y_neg ? (x - y_sh) : (x + y_sh);
  assign y_next = y_neg ? (y + x_sh) : (y - x_sh);
  assign z_next = y_neg ? (z - atan_val) : (z + atan_val);

endmodule

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring unit: returns angle (degrees) and CORDIC-scaled
// magnitude of a signed 8-bit point, one iteration per enabled clock.
module cordic_vector
  import cordic_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic signed [7:0]    xin,
  input  logic signed [7:0]    yin,
  output logic                 busy,
  output logic                 done,
  output logic signed [AW-1:0] degrees,
  output logic        [IW-1:0] magnitude
);

  state_t state, state_next;

  logic        [CW-1:0] step_cnt;
  logic signed [IW-1:0] x, y, x_step, y_step, x_init, y_init;
  logic signed [AW-1:0] z, z_step, z_init;
  logic signed [IW-1:0] xin_ext, yin_ext;
  logic                 zero_flag;
  logic                 load, step, finish;

  assign xin_ext = {{(IW-8){xin[7]}}, xin};
  assign yin_ext = {{(IW-8){yin[7]}}, yin};

  // Fold the left half-plane into the right so the iterations converge.
  always_comb begin
    x_init = xin_ext;
    y_init = yin_ext;
    z_init = '0;
    if (xin[7]) begin
      if (!yin[7]) begin
        x_init = yin_ext;
        y_init = -xin_ext;
        z_init = QUARTER;
      end else begin
        x_init = -yin_ext;
        y_init = xin_ext;
        z_init = -QUARTER;
      end
    end
  end

  cordic_vec_step u_step (
    .x        (x),
    .y        (y),
    .z        (z),
    .shift    (step_cnt),
    .atan_val (atan_deg(step_cnt)),
    .x_next   (x_step),
    .y_next   (y_step),
    .z_next   (z_step)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    if (enable) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            load       = 1'b1;
            state_next = S_ITER;
          end
        end
        S_ITER: begin
          step = 1'b1;
          if (step_cnt == LAST_STEP) begin
            finish     = 1'b1;
            state_next = S_DONE;
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      step_cnt  <= '0;
      zero_flag <= 1'b0;
      degrees   <= '0;
      magnitude <= '0;
    end else begin
      if (load) begin
        x         <= x_init;
        y         <= y_init;
        z         <= z_init;
        step_cnt  <= '0;
        zero_flag <= (xin == 8'sd0) && (yin == 8'sd0);
      end else if (step) begin
        x        <= x_step;
        y        <= y_step;
        z        <= z_step;
        step_cnt <= finish ? '0 : step_cnt + 1'b1;
      end
      if (finish) begin
        magnitude <= x_step;
        degrees   <= zero_flag ? '0 : z_step;
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_cordic_vector.sv
// Randomised self-checking bench for cordic_vector against an integer model
// of the vectoring algorithm.
module tb_cordic_vector;
  import cordic_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b1;
  logic                 start = 1'b0;
  logic signed [7:0]    xin = '0;
  logic signed [7:0]    yin = '0;
  logic                 busy;
  logic                 done;
  logic signed [AW-1:0] degrees;
  logic        [IW-1:0] magnitude;

  int tests_run = 0;
  int tests_failed = 0;
  int atan_tab [7] = '{45, 27, 14, 7, 4, 2, 1};

  always #5 clk = ~clk;

  cordic_vector dut (
    .clock     (clk),
    .reset     (rst_n),
    .enable    (enable),
    .start     (start),
    .xin       (xin),
    .yin       (yin),
    .busy      (busy),
    .done      (done),
    .degrees   (degrees),
    .magnitude (magnitude)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int xv, input int yv, output int deg, output int mag);
    int x, y, z, xn, yn;
    if (xv >= 0) begin
      x = xv;  y = yv;  z = 0;
    end else if (yv >= 0) begin
      x = yv;  y = -xv; z = 90;
    end else begin
      x = -yv; y = xv;  z = -90;
    end
    for (int i = 0; i < 7; i++) begin
      if (y >= 0) begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i];
      end else begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i];
      end
      x = xn;
      y = yn;
    end
    mag = x;
    deg = (xv == 0 && yv == 0) ? 0 : z;
  endfunction

  task automatic do_op(input int xv, input int yv, input int stall_at, input int stall_len,
                       input bit repulse, output int deg, output int mag);
    int exp_deg, exp_mag, lat, busy_cnt, extra;
    model(xv, yv, exp_deg, exp_mag);
    @(negedge clk);
    xin = 8'(xv); yin = 8'(yv); start = 1'b1; enable = 1'b1;
    @(negedge clk);
    check("busy_after_start", int'(busy), 1);
    start = repulse;
    xin = 8'($urandom);
    yin = 8'($urandom);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int c = 1; c <= 40; c++) begin
      enable = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
    enable = 1'b1;
    check("latency", lat, 7 + stall_len);
    check("busy_cycles", busy_cnt, 8 + stall_len);
    deg = int'(degrees);
    mag = int'(magnitude);
    check("degrees", deg, exp_deg);
    check("magnitude", mag, exp_mag);
    check("mag_range", int'(mag < 512), 1);
    @(negedge clk);
    check("done_pulse_width", int'(done), 0);
    check("idle_after_done", int'(busy), 0);
    start = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("no_extra_done", extra, 0);
    check("degrees_hold", int'(degrees), exp_deg);
    $display("[TB] op x=%0d y=%0d stall=%0d@%0d repulse=%0d -> deg=%0d mag=%0d (model %0d %0d)",
             xv, yv, stall_len, stall_at, repulse, deg, mag, exp_deg, exp_mag);
  endtask

  initial begin
    int d, m, d_ref, m_ref, dones;
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_degrees", int'(degrees), 0);
    check("reset_magnitude", int'(magnitude), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(10, 0, 0, 0, 1'b0, d, m);
    check("x10_deg_const", d, -2);
    check("x10_mag_const", m, 20);

    do_op(-10, 0, 0, 0, 1'b0, d, m);
    check("xm10_deg_const", d, 184);
    check("xm10_mag_const", m, 18);

    do_op(0, 0, 0, 0, 1'b0, d, m);
    check("zero_deg", d, 0);
    check("zero_mag", m, 0);

    do_op(-128, -128, 0, 0, 1'b0, d, m);
    check("corner_deg_negative", int'(d < 0), 1);

    do_op(37, -90, 0, 0, 1'b1, d, m);

    do_op(-55, 77, 0, 0, 1'b0, d_ref, m_ref);
    do_op(-55, 77, 4, 3, 1'b0, d, m);
    check("stall_same_deg", d, d_ref);
    check("stall_same_mag", m, m_ref);

    // Reset in the middle of an operation, before edge E3.
    @(negedge clk);
    xin = 8'sd20; yin = 8'sd30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_degrees", int'(degrees), 0);
    check("midreset_magnitude", int'(magnitude), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midreset_no_done", dones, 0);
    $display("[TB] op mid-operation reset x=20 y=30");

    for (int k = 0; k < 24; k++) begin
      int xv, yv, sl, sa;
      bit rp;
      xv = int'($urandom_range(255)) - 128;
      yv = int'($urandom_range(255)) - 128;
      sl = int'($urandom_range(3));
      sa = int'($urandom_range(7, 1));
      rp = 1'($urandom_range(1));
      do_op(xv, yv, sa, sl, rp, d, m);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
